c5gx_input_debouncer: RTL and testbench

//   Conditions the raw C5GX board inputs (KEY[3:0], SW[9:0]) before they reach
//   the MIPSfpga-plus system: polarity normalisation, 2-FF synchronisation and
//   per-bit debounce. Sits between the board top-level pins and the system's

---
 rtl/c5gx_board_pkg.sv | 31 +++
 rtl/c5gx_debounce_bit.sv | 97 +++++++++
 rtl/c5gx_input_debouncer.sv | 48 ++++
 tb/tb_c5gx_input_debouncer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/c5gx_board_pkg.sv
// Shared board constants for the C5GX input conditioning path.
//
// Purpose : widths, bit positions and defaults for the KEY[3:0] / SW[9:0]
//           inputs feeding the MIPSfpga-plus GPIO block.
// Ports   : none (package).
package c5gx_board_pkg;

  localparam int C5GX_KEY_W = 4;
  localparam int C5GX_SW_W  = 10;
  localparam int C5GX_IN_W  = C5GX_KEY_W + C5GX_SW_W;

  // 10 ms at 50 MHz.
  localparam int C5GX_DEBOUNCE_CYCLES = 500000;

  // Bit positions inside the conditioned input vector: keys low, switches above.
  localparam int C5GX_KEY0_IDX = 0;
  localparam int C5GX_KEY1_IDX = 1;
  localparam int C5GX_KEY2_IDX = 2;
  localparam int C5GX_KEY3_IDX = 3;
  localparam int C5GX_SW0_IDX  = C5GX_KEY_W;
  localparam int C5GX_SW9_IDX  = C5GX_KEY_W + C5GX_SW_W - 1;

  // Keys are active-low on the board; switches are active-high.
  localparam logic [C5GX_IN_W-1:0] C5GX_INVERT_MASK = 14'h000F;

  // Counter width that can hold values 0..cycles.
  function automatic int c5gx_cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/c5gx_debounce_bit.sv
// One-bit synchroniser + debouncer.
//
// Purpose : brings one asynchronous input into the clk domain through two
//           flops and accepts a new level only after it has been stable at
//           the synchroniser output for DEBOUNCE_CYCLES consecutive cycles.
// Ports   : clk      system clock
//           rst      asynchronous active-high reset
//           din      asynchronous, already polarity-normalised input
//           clean_o  debounced level
//           rise_o   one-cycle pulse in the first cycle clean_o is 1
//           fall_o   one-cycle pulse in the first cycle clean_o is 0
// Config  : C5GX_DEBOUNCE_EDGE_EN enables the registered rise/fall pulses;
//           without it both pulse outputs are constant 0.
module c5gx_debounce_bit
  import c5gx_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C5GX_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = c5gx_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             clean_q, clean_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cnt_d   = '0;
    clean_d = clean_q;
    if (sync2_q != clean_q) begin
      // Terminal count: accept the new level and restart, so the counter
      // never needs to wrap.
      if (cnt_q == CNT_LAST) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Equal levels leave cnt_d at 0: any glitch restarts the count.
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

`ifdef C5GX_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses are computed from the same transition that updates clean_q, so
  // they coincide with the first cycle of the new clean level.
  always_comb begin
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/c5gx_input_debouncer.sv
// C5GX board input conditioner.
//
// Purpose : normalises polarity of the raw KEY/SW pads (active-low bits are
//           inverted), then synchronises and debounces each bit
//           independently before it reaches the system GPIO inputs.
// Ports   : SI_ClkIn   system clock
//           SI_Reset   asynchronous active-high reset; release is expected
//                      to be synchronous to SI_ClkIn (system reset block)
//           raw_in     raw pad inputs, asynchronous to SI_ClkIn
//           clean_out  debounced, active-high levels
//           rise_o     one-cycle pulse per bit on a clean 0->1 change
//           fall_o     one-cycle pulse per bit on a clean 1->0 change
// Config  : C5GX_DEBOUNCE_EDGE_EN enables rise_o/fall_o; otherwise they are
//           tied to 0 and the port list is unchanged.
module c5gx_input_debouncer
  import c5gx_board_pkg::*;
#(
  parameter int               WIDTH           = C5GX_IN_W,
  parameter int               DEBOUNCE_CYCLES = C5GX_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(C5GX_INVERT_MASK)
) (
  input  logic             SI_ClkIn,
  input  logic             SI_Reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Inversion is a pure XOR ahead of the first sync flop; it adds no state
  // and keeps every downstream bit active-high.
  logic [WIDTH-1:0] norm_in;
  assign norm_in = raw_in ^ INVERT_MASK;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    c5gx_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (SI_ClkIn),
      .rst     (SI_Reset),
      .din     (norm_in[i]),
      .clean_o (clean_out[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

endmodule

// File: tb/tb_c5gx_input_debouncer.sv
// Bench for c5gx_input_debouncer with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected clean_out value, the edge it must appear on,
// and the expected rise/fall pulses; the monitor pops an entry whenever
// clean_out changes and otherwise requires both pulse vectors to be 0.
module tb_c5gx_input_debouncer;

  localparam int W    = 14;
  localparam int D    = 4;
  localparam int LAT  = D + 2;          // edges from input change to clean_out change
  localparam logic [W-1:0] IDLE = 14'h000F;  // keys released, switches off

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw_in = 14'h3FFF;
  logic [W-1:0] clean_out, rise_o, fall_o;

  always #5 clk = ~clk;

  c5gx_input_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .INVERT_MASK     (14'h000F)
  ) dut (
    .SI_ClkIn  (clk),
    .SI_Reset  (rst),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // number of rising edges seen so far

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rise_q[$];
  logic [W-1:0] exp_fall_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] exp_clean = '0;

  task automatic check_vec(input string name, input logic [W-1:0] got,
                           input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called right after an input change: the new clean value must show up
  // LAT edges later with matching pulses.
  task automatic expect_change(input logic [W-1:0] new_val);
    logic [W-1:0] r, f;
`ifdef C5GX_DEBOUNCE_EDGE_EN
    r = new_val & ~exp_clean;
    f = ~new_val & exp_clean;
`else
    r = '0;
    f = '0;
`endif
    exp_q.push_back(new_val);
    exp_rise_q.push_back(r);
    exp_fall_q.push_back(f);
    exp_cyc_q.push_back(cyc + LAT);
    exp_clean = new_val;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        prev = clean_out;
      end else if (clean_out !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: got %h previous %h (edge %0d)",
                   clean_out, prev, cyc);
        end else begin
          check_vec("clean_out", clean_out, exp_q.pop_front());
          check_int("change_edge", cyc, exp_cyc_q.pop_front());
          check_vec("rise_o", rise_o, exp_rise_q.pop_front());
          check_vec("fall_o", fall_o, exp_fall_q.pop_front());
        end
        prev = clean_out;
      end else begin
        check_vec("rise_idle", rise_o, '0);
        check_vec("fall_idle", fall_o, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    raw_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [W-1:0] r;

    // 1: reset with every pad high, then release with everything idle.
    idle(3);
    check_vec("reset_clean", clean_out, '0);
    check_vec("reset_rise", rise_o, '0);
    check_vec("reset_fall", fall_o, '0);
    raw_in = IDLE;
    @(negedge clk);
    rst = 1'b0;
    idle(12);
    check_vec("idle_clean", clean_out, '0);

    // 2: KEY0 press and release.
    drive(IDLE & ~14'h0001);
    expect_change(14'h0001);
    idle(10);
    drive(IDLE);
    expect_change(14'h0000);
    idle(10);

    // 3: SW0 (bit 4) glitch of 3 cycles is rejected; 4 cycles is accepted.
    drive(IDLE | 14'h0010);
    idle(2);
    drive(IDLE);
    idle(10);
    drive(IDLE | 14'h0010);
    expect_change(14'h0010);
    idle(3);
    drive(IDLE);
    expect_change(14'h0000);
    idle(12);

    // 4: bit 5 bounces every 2 cycles while KEY1 is pressed and held.
    r = IDLE & ~14'h0002;
    drive(r | 14'h0020);
    expect_change(14'h0002);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      drive(r);
      idle(1);
      drive(r | 14'h0020);
      idle(1);
    end
    drive(r);
    idle(1);
    drive(r | 14'h0020);
    expect_change(14'h0022);
    idle(10);
    drive(IDLE);
    expect_change(14'h0000);
    idle(10);

    // 5: every bit changes in the same cycle.
    drive(14'h3FF0);
    expect_change(14'h3FFF);
    idle(10);
    drive(IDLE);
    expect_change(14'h0000);
    idle(10);

    // 6: reset three edges into a count discards the progress.
    drive(IDLE | 14'h0040);
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vec("midreset_clean", clean_out, '0);
    @(negedge clk);
    rst = 1'b0;
    expect_change(14'h0040);
    idle(12);
    drive(IDLE);
    expect_change(14'h0000);
    idle(12);

    check_int("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
